// File: rtl/key_led_ctrl.sv
// key_led_ctrl: debounced multi-channel push-buttons driving per-channel OFF/ON/BLINK LEDs
module key_led_ctrl #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_DIV        = 50_000,
  parameter int HALF_TICKS      = 125,
  parameter int RATE_W          = 2
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [N_CH-1:0]     key_n,
  input  logic [RATE_W-1:0]   rate,
  output logic [N_CH-1:0]     key_level,
  output logic [N_CH-1:0]     press_pulse,
  output logic [N_CH-1:0]     led,
  output logic [2*N_CH-1:0]   mode
);
  localparam int     DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int     PW   = $clog2(TICK_DIV);
  localparam longint MAXL = longint'(HALF_TICKS) << (2 ** RATE_W - 1);
  localparam int     BW   = $clog2(MAXL + 1);

  typedef enum logic [1:0] {OFF = 2'b00, ON = 2'b01, BLINK = 2'b10} mode_e;

  logic [N_CH-1:0] s1_q, ks_q;
  logic [PW-1:0]   pcnt_q;
  logic [BW-1:0]   limit;
  logic            tick;

  assign tick  = pcnt_q == PW'(TICK_DIV - 1);
  assign limit = BW'(HALF_TICKS) << rate;

  always_ff @(posedge sys_clk) begin
    s1_q   <= sys_rst ? '1 : key_n;
    ks_q   <= sys_rst ? '1 : s1_q;
    pcnt_q <= (sys_rst || tick) ? '0 : pcnt_q + 1'b1;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DW-1:0] cnt_q;
    logic          lvl_q, lvl_d1_q, pp_q, ph_q, ph_d, led_q;
    logic [BW-1:0] bcnt_q, bcnt_d;
    mode_e         st_q, st_d;

    // the counter restarts whenever the synced key matches, so only an unbroken run is accepted
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        cnt_q    <= '0;
        lvl_q    <= 1'b1;
        lvl_d1_q <= 1'b1;
        pp_q     <= 1'b0;
      end else begin
        cnt_q    <= (ks_q[i] == lvl_q || cnt_q == DW'(DEBOUNCE_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
        lvl_q    <= (ks_q[i] != lvl_q && cnt_q == DW'(DEBOUNCE_CYCLES - 1)) ? ks_q[i] : lvl_q;
        lvl_d1_q <= lvl_q;
        pp_q     <= lvl_d1_q & ~lvl_q;
      end
    end

    // a press outranks a blink toggle on the same edge
    always_comb begin
      st_d   = st_q;
      ph_d   = ph_q;
      bcnt_d = bcnt_q;
      if (pp_q) begin
        st_d   = st_q == OFF ? ON : st_q == ON ? BLINK : OFF;
        ph_d   = st_d == BLINK;
        bcnt_d = '0;
      end else if (st_q == BLINK && tick) begin
        bcnt_d = bcnt_q >= limit - 1'b1 ? '0 : bcnt_q + 1'b1;
        ph_d   = bcnt_q >= limit - 1'b1 ? ~ph_q : ph_q;
      end
    end

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        st_q   <= OFF;
        ph_q   <= 1'b0;
        bcnt_q <= '0;
        led_q  <= 1'b0;
      end else begin
        st_q   <= st_d;
        ph_q   <= ph_d;
        bcnt_q <= bcnt_d;
        led_q  <= st_d == BLINK ? ph_d : st_d == ON;
      end
    end

    assign key_level[i]   = lvl_q;
    assign press_pulse[i] = pp_q;
    assign led[i]         = led_q;
    assign mode[2*i +: 2] = st_q;
  end
endmodule
